cpu_step_ctrl: RTL and testbench
================================

# cpu_step_ctrl

CPU execution controller between the board inputs and the CPU/RAM write path. Converts the mode switches and the raw step button into a single-cycle-qualified `cpu_en` so the programme can free-run, run slowly, single-step or halt. Optionally counts executed CPU cycles for the on-screen cycle-counter display.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, 1_000_000: consecutive stable cycles required to accept a button level change (20 ms at 50 MHz); minimum 2.
- `SLOW_DIV`, 25_000_000: CLK_50 cycles per enable pulse in SLOW mode (2 Hz); minimum 2.
- `COUNT_WIDTH`, 16: width of `cycle_count`.

Ports:
- `CLK_50`  in  1  system clock; the only clock.
- `resetN`  in  1  asynchronous, active-low reset.
- `step_btn`  in  1  raw step button (BUTTON[1]), active-low, asynchronous to CLK_50.
- `mode`  in  2  raw mode switches (SW[1:0]), asynchronous: 00 RUN, 01 SLOW, 10 STEP, 11 HALT.
- `cpu_en`  out  1  registered; CPU and RAM write-enable qualifier for this cycle.
- `halted`  out  1  registered; 1 while in STEP or HALT state.
- `cycle_count`  out  COUNT_WIDTH  registered count of cycles with `cpu_en`=1.

## Operation
- Synchronisers: 2-flop chain on `step_btn` (reset 1 = released), 2-flop chain on `mode` (reset 2'b11 = HALT).
- Debouncer: counter clears whenever synchronised button equals debounced level; otherwise increments; on reaching DEBOUNCE_CYCLES-1, debounced level toggles and counter clears. Debounced level resets to 1.
- Press detect: one-cycle `step_pulse` on debounced 1->0 transition. Release produces nothing.
- FSM states RUN, SLOW, STEP, HALT; next state = decoded synchronised `mode` every cycle (any state to any state). Reset state HALT.
- Prescaler (width clog2(SLOW_DIV)): cleared in every state except SLOW; in SLOW counts 0..SLOW_DIV-1 and wraps to 0.
- `cpu_en` next value: RUN 1; SLOW 1 iff prescaler == SLOW_DIV-1; STEP 1 iff `step_pulse`; HALT 0.
- `step_pulse` outside STEP is discarded, never queued.
- `halted` next value: 1 iff next state is STEP or HALT.
- `cycle_count` increments by 1 on each edge where `cpu_en`=1; wraps from 2^COUNT_WIDTH-1 to 0; unsigned modulo arithmetic.

## Timing
- Reset values: `cpu_en`=0, `halted`=1, `cycle_count`=0, state HALT, prescaler 0, debounce counter 0.
- Reset mid-operation: all registers return to reset values immediately (asynchronous); a press in progress is lost; no `cpu_en` glitch.
- Mode change: `mode` change at edge M is registered by sync stages at M+1, M+2; state updates at M+3; `cpu_en`/`halted` reflect new mode after edge M+3.
- SLOW entry: prescaler starts at 0 in the first SLOW cycle; first `cpu_en` pulse exactly SLOW_DIV cycles later, then one every SLOW_DIV cycles, each exactly 1 cycle wide.
- Step: debounced level falls at edge N -> `step_pulse` during cycle N..N+1 -> `cpu_en` high for exactly one cycle after edge N+1. Raw press to debounced fall = 2 sync cycles + DEBOUNCE_CYCLES.
- Bounce shorter than DEBOUNCE_CYCLES produces no pulse; one physical press produces exactly one `cpu_en` cycle.
- Mode leaving STEP on the same edge a `step_pulse` occurs: new state governs; pulse is dropped.

## Configuration
- `CYCLE_COUNTER_EN` defined: `cycle_count` register and incrementer present as described.
- Undefined: counter logic removed; `cycle_count` driven constant 0; all other behaviour unchanged.

## Test plan
(bench uses DEBOUNCE_CYCLES=4, SLOW_DIV=5, COUNT_WIDTH=4, `CYCLE_COUNTER_EN` defined unless stated)
- Reset with `mode`=00 held -> `cpu_en`=0, `halted`=1 until edge 3 after release; then `cpu_en`=1 every cycle, `halted`=0, `cycle_count` 1,2,..,15,0 wrap.
- `mode`=01 for 30 cycles -> `cpu_en` high exactly 1 cycle in every 5, first pulse 5 cycles after SLOW entry; `cycle_count` = 6 after 30 SLOW cycles.
- `mode`=10, press with bounce (0/1/0 each 2 cycles) then held low 10 cycles, release -> exactly one `cpu_en` cycle, `cycle_count` 0->1.
- `mode`=11, valid press -> `cpu_en` stays 0, `cycle_count` unchanged; switch to 10 afterwards -> no deferred step.
- In RUN, assert `resetN`=0 asynchronously mid-cycle with `cycle_count`=9 -> `cpu_en`=0, `cycle_count`=0, `halted`=1 immediately.
- `CYCLE_COUNTER_EN` undefined, RUN for 20 cycles -> `cycle_count` constant 0, `cpu_en` timing identical to first scenario.

Source files
------------

// File: rtl/cpu_step_ctrl.sv
// CPU execution controller: mode/step-button conditioning into a per-cycle cpu_en qualifier.
// Define CYCLE_COUNTER_EN to build the executed-cycle counter; otherwise cycle_count is tied to 0.
module cpu_step_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int SLOW_DIV        = 25_000_000,
  parameter int COUNT_WIDTH     = 16
) (
  input  logic                   CLK_50,
  input  logic                   resetN,
  input  logic                   step_btn,
  input  logic [1:0]             mode,
  output logic                   cpu_en,
  output logic                   halted,
  output logic [COUNT_WIDTH-1:0] cycle_count
);

  localparam int DB_W  = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int PRE_W = (SLOW_DIV > 2) ? $clog2(SLOW_DIV) : 1;

  localparam logic [DB_W-1:0]  DB_MAX  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DB_W-1:0]  DB_ONE  = DB_W'(1);
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(SLOW_DIV - 1);
  localparam logic [PRE_W-1:0] PRE_ONE = PRE_W'(1);

  localparam logic [1:0] ST_RUN  = 2'd0;
  localparam logic [1:0] ST_SLOW = 2'd1;
  localparam logic [1:0] ST_STEP = 2'd2;
  localparam logic [1:0] ST_HALT = 2'd3;

  logic             btn_meta_r;
  logic             btn_sync_r;
  logic [1:0]       mode_meta_r;
  logic [1:0]       mode_sync_r;
  logic [DB_W-1:0]  db_cnt_r;
  logic             btn_db_r;
  logic             btn_db_prev_r;
  logic             step_pulse_s;
  logic [1:0]       state_r;
  logic [1:0]       state_next_s;
  logic [PRE_W-1:0] pre_r;
  logic             cpu_en_next_s;
  logic             halted_next_s;
  logic             cpu_en_r;
  logic             halted_r;

  function automatic logic [1:0] decode_mode(input logic [1:0] m);
    case (m)
      2'b00:   decode_mode = ST_RUN;
      2'b01:   decode_mode = ST_SLOW;
      2'b10:   decode_mode = ST_STEP;
      2'b11:   decode_mode = ST_HALT;
      default: decode_mode = ST_HALT;
    endcase
  endfunction

  // Two-flop synchronisers; reset values read as "button released" and HALT.
  always_ff @(posedge CLK_50 or negedge resetN) begin
    if (!resetN) begin
      btn_meta_r  <= 1'b1;
      btn_sync_r  <= 1'b1;
      mode_meta_r <= 2'b11;
      mode_sync_r <= 2'b11;
    end else begin
      btn_meta_r  <= step_btn;
      btn_sync_r  <= btn_meta_r;
      mode_meta_r <= mode;
      mode_sync_r <= mode_meta_r;
    end
  end

  // Debouncer: the accepted level only flips after DEBOUNCE_CYCLES of disagreement.
  always_ff @(posedge CLK_50 or negedge resetN) begin
    if (!resetN) begin
      db_cnt_r <= {DB_W{1'b0}};
      btn_db_r <= 1'b1;
    end else if (btn_sync_r == btn_db_r) begin
      db_cnt_r <= {DB_W{1'b0}};
      btn_db_r <= btn_db_r;
    end else if (db_cnt_r == DB_MAX) begin
      db_cnt_r <= {DB_W{1'b0}};
      btn_db_r <= ~btn_db_r;
    end else begin
      db_cnt_r <= db_cnt_r + DB_ONE;
      btn_db_r <= btn_db_r;
    end
  end

  // Previous debounced level for edge detection.
  always_ff @(posedge CLK_50 or negedge resetN) begin
    if (!resetN) begin
      btn_db_prev_r <= 1'b1;
    end else begin
      btn_db_prev_r <= btn_db_r;
    end
  end

  // Press (falling edge of the debounced level) only; release is ignored.
  assign step_pulse_s = btn_db_prev_r & ~btn_db_r;
  assign state_next_s = decode_mode(mode_sync_r);

  // Prescaler free-runs only while the current state is SLOW.
  always_ff @(posedge CLK_50 or negedge resetN) begin
    if (!resetN) begin
      pre_r <= {PRE_W{1'b0}};
    end else if (state_r != ST_SLOW) begin
      pre_r <= {PRE_W{1'b0}};
    end else if (pre_r == PRE_MAX) begin
      pre_r <= {PRE_W{1'b0}};
    end else begin
      pre_r <= pre_r + PRE_ONE;
    end
  end

  // Enable is decided by the incoming state, so a pulse seen while leaving STEP is dropped.
  always_comb begin
    cpu_en_next_s = 1'b0;
    case (state_next_s)
      ST_RUN:  cpu_en_next_s = 1'b1;
      ST_SLOW: cpu_en_next_s = (pre_r == PRE_MAX);
      ST_STEP: cpu_en_next_s = step_pulse_s;
      ST_HALT: cpu_en_next_s = 1'b0;
      default: cpu_en_next_s = 1'b0;
    endcase
    halted_next_s = (state_next_s == ST_STEP) || (state_next_s == ST_HALT);
  end

  // State and registered outputs.
  always_ff @(posedge CLK_50 or negedge resetN) begin
    if (!resetN) begin
      state_r  <= ST_HALT;
      cpu_en_r <= 1'b0;
      halted_r <= 1'b1;
    end else begin
      state_r  <= state_next_s;
      cpu_en_r <= cpu_en_next_s;
      halted_r <= halted_next_s;
    end
  end

  assign cpu_en = cpu_en_r;
  assign halted = halted_r;

`ifdef CYCLE_COUNTER_EN
  localparam logic [COUNT_WIDTH-1:0] CNT_ONE = COUNT_WIDTH'(1);
  logic [COUNT_WIDTH-1:0] cnt_r;

  // Executed-cycle counter, wraps modulo 2^COUNT_WIDTH.
  always_ff @(posedge CLK_50 or negedge resetN) begin
    if (!resetN) begin
      cnt_r <= {COUNT_WIDTH{1'b0}};
    end else if (cpu_en_r) begin
      cnt_r <= cnt_r + CNT_ONE;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign cycle_count = cnt_r;
`else
  assign cycle_count = {COUNT_WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Table-driven bench for cpu_step_ctrl (DEBOUNCE_CYCLES=4, SLOW_DIV=5, COUNT_WIDTH=4).
// Expected count follows CYCLE_COUNTER_EN: the modelled count when defined, 0 otherwise.
module tb_cpu_step_ctrl;
  localparam int CW = 4;

  logic          CLK_50 = 1'b0;
  logic          resetN;
  logic          step_btn;
  logic [1:0]    mode;
  logic          cpu_en;
  logic          halted;
  logic [CW-1:0] cycle_count;

  always #5 CLK_50 = ~CLK_50;

  cpu_step_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .SLOW_DIV(5),
    .COUNT_WIDTH(CW)
  ) dut (
    .CLK_50(CLK_50),
    .resetN(resetN),
    .step_btn(step_btn),
    .mode(mode),
    .cpu_en(cpu_en),
    .halted(halted),
    .cycle_count(cycle_count)
  );

  typedef struct packed {
    logic [1:0]    mode;
    logic          btn;
    logic          en;
    logic          h;
    logic [CW-1:0] cnt;
  } vec_t;

  typedef struct packed {
    logic          en;
    logic          h;
    logic [CW-1:0] cnt;
  } exp_t;

  vec_t tbl [0:255];
  int   n_tbl;
  int   model_cnt;
  logic prev_en;
  exp_t sb_q[$];
  int   n_applied;
  int   n_miss;

  function automatic logic [CW-1:0] count_exp(input int c);
`ifdef CYCLE_COUNTER_EN
    return CW'(c);
`else
    return {CW{1'b0}};
`endif
  endfunction

  // Append a vector; the expected count after this edge includes the previous cycle's enable.
  function automatic void add(input logic [1:0] m, input logic b, input logic e, input logic h);
    vec_t v;
    if (prev_en) model_cnt = model_cnt + 1;
    prev_en = e;
    v.mode = m;
    v.btn  = b;
    v.en   = e;
    v.h    = h;
    v.cnt  = count_exp(model_cnt);
    tbl[n_tbl] = v;
    n_tbl = n_tbl + 1;
  endfunction

  task automatic check(input string name);
    exp_t e;
    n_applied = n_applied + 1;
    if (sb_q.size() == 0) begin
      n_miss = n_miss + 1;
      $display("FAIL %s: scoreboard empty, got en=%b halted=%b count=%0d", name, cpu_en, halted, cycle_count);
    end else begin
      e = sb_q.pop_front();
      if (cpu_en !== e.en || halted !== e.h || cycle_count !== e.cnt) begin
        n_miss = n_miss + 1;
        $display("FAIL %s: got en=%b halted=%b count=%0d, expected en=%b halted=%b count=%0d",
                 name, cpu_en, halted, cycle_count, e.en, e.h, e.cnt);
      end
    end
  endtask

  // Called at a falling edge: drive, let one rising edge sample, compare at the next falling edge.
  task automatic apply(input vec_t v, input string name);
    exp_t e;
    mode     = v.mode;
    step_btn = v.btn;
    e.en  = v.en;
    e.h   = v.h;
    e.cnt = v.cnt;
    sb_q.push_back(e);
    @(posedge CLK_50);
    @(negedge CLK_50);
    check(name);
  endtask

  task automatic push_exp(input logic en, input logic h, input logic [CW-1:0] c);
    exp_t e;
    e.en  = en;
    e.h   = h;
    e.cnt = c;
    sb_q.push_back(e);
  endtask

  initial begin
    int first_post;
    resetN    = 1'b0;
    mode      = 2'b00;
    step_btn  = 1'b1;
    n_tbl     = 0;
    model_cnt = 0;
    prev_en   = 1'b0;
    n_applied = 0;
    n_miss    = 0;

    // RUN from reset: two sync edges, then enabled every cycle; count wraps 15 -> 0.
    for (int j = 0; j < 20; j++) add(2'b00, 1'b1, (j >= 2), (j < 2));
    // SLOW: one pulse every 5 cycles, first one 5 cycles after entry.
    for (int j = 0; j < 33; j++)
      add(2'b01, 1'b1, (j < 2) || ((j - 2) > 0 && ((j - 2) % 5) == 0), 1'b0);
    // STEP: short bounce, then a held press; exactly one enable cycle.
    for (int j = 0; j < 30; j++)
      add(2'b10, !((j >= 4 && j <= 5) || (j >= 8 && j <= 17)), (j == 14), (j >= 2));
    // HALT: a valid press is ignored.
    for (int j = 0; j < 30; j++) add(2'b11, !(j >= 4 && j <= 13), 1'b0, 1'b1);
    // Back to STEP: the press taken in HALT is not replayed.
    for (int j = 0; j < 10; j++) add(2'b10, 1'b1, 1'b0, 1'b1);
    // Leave STEP on the very edge the step pulse would be consumed.
    for (int j = 0; j < 20; j++) add((j < 4) ? 2'b10 : 2'b11, (j >= 10), 1'b0, 1'b1);
    // RUN until the count reads 9, ahead of the asynchronous reset.
    for (int j = 0; j < 40; j++) begin
      add(2'b00, 1'b1, (j >= 2), (j < 2));
      if (j >= 2 && (model_cnt % 16) == 9) break;
    end

    repeat (3) @(posedge CLK_50);
    @(negedge CLK_50);
    push_exp(1'b0, 1'b1, {CW{1'b0}});
    check("reset_hold");
    resetN = 1'b1;

    for (int i = 0; i < n_tbl; i++) apply(tbl[i], $sformatf("vec%0d", i));

    // Asynchronous reset in the middle of the low clock phase.
    #2;
    resetN = 1'b0;
    #1;
    push_exp(1'b0, 1'b1, {CW{1'b0}});
    check("async_reset");
    @(posedge CLK_50);
    @(negedge CLK_50);
    push_exp(1'b0, 1'b1, {CW{1'b0}});
    check("reset_held_over_edge");
    resetN = 1'b1;

    // Restart in RUN after the reset.
    model_cnt  = 0;
    prev_en    = 1'b0;
    first_post = n_tbl;
    for (int j = 0; j < 4; j++) add(2'b00, 1'b1, (j >= 2), (j < 2));
    for (int i = first_post; i < n_tbl; i++) apply(tbl[i], $sformatf("post_reset%0d", i - first_post));

    if (sb_q.size() != 0) begin
      n_miss = n_miss + 1;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miss);
    $finish;
  end

endmodule
